z80_reti: RTL and testbench
===========================

Name: z80_reti

Overview:
- Bus-side monitor that watches Z80 CPU control and data signals and generates the interrupt-protocol strobes that daisy-chained peripherals (CTC, PIO, SIO) consume.
- Outputs:
  - O_SPM1: interrupt-acknowledge level.
  - O_RETI: single-tick pulse on completion of an ED 4D fetch.
  - O_RETN: single-tick pulse on completion of an ED 45-family fetch.
  - O_EDM1: level flagging that an ED prefix has just been fetched.
- Sits beside the CPU core. One instance feeds every peripheral's I_SPM1/I_RETI inputs.

Parameters:
- UNDOC_RETN, 1, when 1, ED 55/5D/65/6D/75/7D also decode as RETN; when 0, only ED 45 does.
- SPM1_COMB, 0, when 1, O_SPM1 is combinational (~I_M1_n & ~I_IORQ_n); when 0, it is registered on I_CLKEN.

Ports:
- I_CLK  in  1  system clock
- I_RESET_n  in  1  asynchronous active-low reset
- I_CLKEN  in  1  CPU clock enable; all state advances only when it is high
- I_M1_n  in  1  CPU M1
- I_MREQ_n  in  1  CPU MREQ
- I_IORQ_n  in  1  CPU IORQ
- I_RD_n  in  1  CPU RD
- I_D  in  8  CPU data-in bus (value driven to the CPU)
- O_SPM1  out  1  interrupt-acknowledge cycle active
- O_RETI  out  1  RETI completed; one I_CLKEN period wide
- O_RETN  out  1  RETN completed; one I_CLKEN period wide
- O_EDM1  out  1  previous opcode fetch was an ED prefix

Behaviour:
- Reset/clock: one clock, I_CLK. Reset is asynchronous, active-low, on I_RESET_n.
  - On reset, all outputs are 0, the state is IDLE and the opcode latch is 00.
  - A reset asserted mid-instruction aborts any pending ED/CB and suppresses any pulse.
- Fetch detect: fetch = ~I_M1_n & ~I_MREQ_n & ~I_RD_n.
  - On every I_CLKEN tick with fetch true, latch I_D into op_r. The last sampled value wins.
- M1 end: m1_r holds I_M1_n sampled on I_CLKEN. The event m1_end (m1_r==0 & I_M1_n==1 on an I_CLKEN tick) closes the cycle.
  - A fetch-flagged cycle is decoded at m1_end.
  - An ack-flagged cycle returns to IDLE at m1_end without decoding.
- Ack: ack = ~I_M1_n & ~I_IORQ_n.
  - Registered mode: O_SPM1 is set on the I_CLKEN tick where ack is seen and cleared on the tick where I_M1_n is high. Latency is 1 tick.
  - An ack cycle forces the state to IDLE and never decodes op_r.
- States: IDLE, PFX_ED, PFX_CB. Transitions are evaluated at m1_end of a fetch cycle.
  - IDLE: op ED -> PFX_ED; op CB -> PFX_CB; anything else (DD, FD included) -> IDLE.
  - PFX_ED: op 4D -> pulse O_RETI; op in the RETN set -> pulse O_RETN; every op, ED included -> IDLE.
  - PFX_CB: any op -> IDLE. An ED here is an operand and does not arm.
  - DD/FD CB d op: d and op are non-M1 reads, so they are ignored and the state stays PFX_CB until the next M1 fetch.
- O_EDM1: equals (state==PFX_ED). It asserts the cycle after the ED m1_end and drops at the next m1_end.
- Pulses:
  - O_RETI/O_RETN assert at the I_CLKEN tick containing the decoding m1_end.
  - They stay high until the next I_CLKEN tick, so clken-gated consumers see exactly one tick. They are never both high.
- Boundaries:
  - HALT: repeated NOP M1 cycles from IDLE produce nothing.
  - I_CLKEN held low freezes everything, including pulse width.
  - A fetch and an ack within the same M1 is impossible on a Z80. If it occurs anyway, ack wins and no pulse is produced.

Decomposition:
- Package z80_bus_pkg:
  - Opcode constants: OP_ED=8'hED, OP_CB=8'hCB, OP_DD=8'hDD, OP_FD=8'hFD, OP_RETI=8'h4D, OP_RETN=8'h45.
  - RETN alias set.
  - 2-bit state encoding.
  - Helper function is_retn(op, undoc).
- No sub-module. Edge detect, latch, FSM and pulse stretch live in a single always block plus output assigns.

Test Plan:
- Reset mid-pulse: drive I_RESET_n low while O_RETI is high -> all outputs 0 immediately, asynchronously; after release, a lone 4D fetch gives no pulse.
- RETI decode: fetch ED then 4D, I_CLKEN every 4th clock -> O_EDM1 high between the fetches; O_RETI high for exactly 4 I_CLK cycles starting at the 4D m1_end; O_RETN stays 0.
- RETN aliases: ED 45 -> O_RETN pulse. ED 5D -> pulse with UNDOC_RETN=1, no pulse with UNDOC_RETN=0. ED 44 -> no pulse.
- Prefix rules: CB ED 4D -> no pulse. DD ED 4D -> O_RETI pulse. ED ED 4D -> no pulse. DD CB 05 ED with non-M1 reads -> no pulse.
- Ack cycle: M1+IORQ for 3 ticks with I_D=ED -> O_SPM1 rises 1 tick after ack and falls on the tick M1_n returns high; state stays IDLE; a following 4D fetch gives no pulse.
- Clock-enable stall: I_CLKEN low for 20 clocks while O_RETI is high -> O_RETI stays high; it clears on the first tick after I_CLKEN returns.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// ============================================================================
//  Module  : z80_bus_pkg
//  Brief   : Z80 opcode constants, prefix-state encoding and RETN decode helper
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package z80_bus_pkg;

   localparam logic [7:0] OP_ED   = 8'hED;
   localparam logic [7:0] OP_CB   = 8'hCB;
   localparam logic [7:0] OP_DD   = 8'hDD;
   localparam logic [7:0] OP_FD   = 8'hFD;
   localparam logic [7:0] OP_RETI = 8'h4D;
   localparam logic [7:0] OP_RETN = 8'h45;

   // Undocumented second bytes that the CPU executes exactly like ED 45
   localparam int          RETN_ALIAS_N = 6;
   localparam logic [47:0] RETN_ALIASES = {8'h55, 8'h5D, 8'h65, 8'h6D, 8'h75, 8'h7D};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PFX_ED = 2'd1,
      ST_PFX_CB = 2'd2
   } state_t;

   function automatic logic is_retn(input logic [7:0] op, input logic undoc);
      logic hit;
      hit = (op == OP_RETN);
      if (undoc) begin
         for (int i = 0; i < RETN_ALIAS_N; i++) begin
            if (op == RETN_ALIASES[i*8 +: 8]) hit = 1'b1;
         end
      end
      return hit;
   endfunction

endpackage

`default_nettype wire

// File: rtl/z80_reti.sv
// ============================================================================
//  Module  : z80_reti
//  Brief   : Watches Z80 bus cycles and emits SPM1 / RETI / RETN / EDM1 strobes
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_reti
   import z80_bus_pkg::*;
#(
   parameter bit UNDOC_RETN = 1'b1,
   parameter bit SPM1_COMB  = 1'b0
) (
   input  logic       I_CLK,
   input  logic       I_RESET_n,
   input  logic       I_CLKEN,
   input  logic       I_M1_n,
   input  logic       I_MREQ_n,
   input  logic       I_IORQ_n,
   input  logic       I_RD_n,
   input  logic [7:0] I_D,
   output logic       O_SPM1,
   output logic       O_RETI,
   output logic       O_RETN,
   output logic       O_EDM1
);

   state_t     r_state;
   logic [7:0] r_op;
   logic       r_m1;
   logic       r_fetch_seen;
   logic       r_ack_seen;
   logic       r_reti;
   logic       r_retn;

   state_t     w_state_nxt;
   logic [7:0] w_op_nxt;
   logic       w_fetch_seen_nxt;
   logic       w_ack_seen_nxt;
   logic       w_reti_nxt;
   logic       w_retn_nxt;
   logic       w_fetch;
   logic       w_ack;
   logic       w_m1_end;

   always_comb begin
      w_fetch          = ~I_M1_n & ~I_MREQ_n & ~I_RD_n;
      w_ack            = ~I_M1_n & ~I_IORQ_n;
      w_m1_end         = ~r_m1 & I_M1_n;
      w_state_nxt      = r_state;
      w_op_nxt         = r_op;
      w_fetch_seen_nxt = r_fetch_seen;
      w_ack_seen_nxt   = r_ack_seen;
      w_reti_nxt       = 1'b0;
      w_retn_nxt       = 1'b0;

      if (w_fetch) begin
         w_op_nxt         = I_D;
         w_fetch_seen_nxt = 1'b1;
      end
      if (w_ack) w_ack_seen_nxt = 1'b1;

      // Decode only at the close of the M1 cycle; an acknowledge cycle overrides a fetch
      if (w_m1_end) begin
         w_fetch_seen_nxt = 1'b0;
         w_ack_seen_nxt   = 1'b0;
         if (r_ack_seen) begin
            w_state_nxt = ST_IDLE;
         end else if (r_fetch_seen) begin
            case (r_state)
               ST_IDLE: begin
                  if (r_op == OP_ED)      w_state_nxt = ST_PFX_ED;
                  else if (r_op == OP_CB) w_state_nxt = ST_PFX_CB;
                  else                    w_state_nxt = ST_IDLE;
               end
               ST_PFX_ED: begin
                  w_reti_nxt  = (r_op == OP_RETI);
                  w_retn_nxt  = is_retn(r_op, UNDOC_RETN);
                  w_state_nxt = ST_IDLE;
               end
               default: w_state_nxt = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge I_CLK or negedge I_RESET_n) begin
      if (!I_RESET_n) begin
         r_state      <= ST_IDLE;
         r_op         <= 8'h00;
         r_m1         <= 1'b1;
         r_fetch_seen <= 1'b0;
         r_ack_seen   <= 1'b0;
         r_reti       <= 1'b0;
         r_retn       <= 1'b0;
      end else if (I_CLKEN) begin
         r_state      <= w_state_nxt;
         r_op         <= w_op_nxt;
         r_m1         <= I_M1_n;
         r_fetch_seen <= w_fetch_seen_nxt;
         r_ack_seen   <= w_ack_seen_nxt;
         r_reti       <= w_reti_nxt;
         r_retn       <= w_retn_nxt;
      end
   end

   generate
      if (SPM1_COMB) begin : g_spm1_comb
         assign O_SPM1 = w_ack;
      end else begin : g_spm1_reg
         logic r_spm1;
         always_ff @(posedge I_CLK or negedge I_RESET_n) begin
            if (!I_RESET_n) begin
               r_spm1 <= 1'b0;
            end else if (I_CLKEN) begin
               if (w_ack)       r_spm1 <= 1'b1;
               else if (I_M1_n) r_spm1 <= 1'b0;
            end
         end
         assign O_SPM1 = r_spm1;
      end
   endgenerate

   assign O_RETI = r_reti;
   assign O_RETN = r_retn;
   assign O_EDM1 = (r_state == ST_PFX_ED);

endmodule

`default_nettype wire

// File: tb/tb_z80_reti.sv
// ============================================================================
//  Module  : tb_z80_reti
//  Brief   : Scoreboard bench for z80_reti, two parameterisations side by side
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_z80_reti;

   logic       clk = 1'b0;
   logic       rst_n, clken, m1_n, mreq_n, iorq_n, rd_n;
   logic [7:0] d;
   logic       spm1 [2];
   logic       reti [2];
   logic       retn [2];
   logic       edm1 [2];

   always #5 clk = ~clk;

   // Instance 0: undocumented aliases on, registered SPM1; instance 1: ED 45 only, combinational SPM1
   z80_reti #(.UNDOC_RETN(1'b1), .SPM1_COMB(1'b0)) u_undoc (
      .I_CLK(clk), .I_RESET_n(rst_n), .I_CLKEN(clken), .I_M1_n(m1_n), .I_MREQ_n(mreq_n),
      .I_IORQ_n(iorq_n), .I_RD_n(rd_n), .I_D(d),
      .O_SPM1(spm1[0]), .O_RETI(reti[0]), .O_RETN(retn[0]), .O_EDM1(edm1[0]));

   z80_reti #(.UNDOC_RETN(1'b0), .SPM1_COMB(1'b1)) u_doc (
      .I_CLK(clk), .I_RESET_n(rst_n), .I_CLKEN(clken), .I_M1_n(m1_n), .I_MREQ_n(mreq_n),
      .I_IORQ_n(iorq_n), .I_RD_n(rd_n), .I_D(d),
      .O_SPM1(spm1[1]), .O_RETI(reti[1]), .O_RETN(retn[1]), .O_EDM1(edm1[1]));

   // Expected outcome of one completed M1 cycle: kind 0 none, 1 RETI, 2 RETN
   typedef struct packed {
      logic [1:0] k0;
      logic [1:0] k1;
      logic       ed;
   } exp_t;

   exp_t       exp_q [$];
   int         n_chk  = 0;
   int         n_fail = 0;
   int         div    = 1;
   logic       exp_spm1 = 1'b0;
   logic [7:0] pend     = 8'h00;
   logic [7:0] pool [13] = '{8'hED, 8'hCB, 8'hDD, 8'hFD, 8'h4D, 8'h45, 8'h5D,
                             8'h55, 8'h7D, 8'h44, 8'h00, 8'h76, 8'h6D};

   task automatic chk(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] kind_of(input logic [7:0] op, input bit undoc);
      if (op == 8'h4D) return 2'd1;
      if (op == 8'h45) return 2'd2;
      if (undoc && (op == 8'h55 || op == 8'h5D || op == 8'h65 ||
                    op == 8'h6D || op == 8'h75 || op == 8'h7D)) return 2'd2;
      return 2'd0;
   endfunction

   // One CPU T-state: bus set up, a single enabled clock, then div-1 disabled clocks
   task automatic cpu_tick(input logic a_m1, input logic a_mreq, input logic a_iorq,
                           input logic a_rd, input logic [7:0] a_d);
      m1_n = a_m1; mreq_n = a_mreq; iorq_n = a_iorq; rd_n = a_rd; d = a_d;
      clken = 1'b1;
      @(posedge clk); #1;
      if (!a_m1 && !a_iorq) exp_spm1 = 1'b1;
      else if (a_m1)        exp_spm1 = 1'b0;
      chk("spm1_reg", spm1[0], exp_spm1);
      chk("spm1_comb", spm1[1], !a_m1 && !a_iorq);
      @(negedge clk);
      clken = 1'b0;
      repeat (div - 1) @(negedge clk);
   endtask

   task automatic idle();
      cpu_tick(1'b1, 1'b1, 1'b1, 1'b1, 8'($urandom));
   endtask

   task automatic fetch(input logic [7:0] op);
      exp_t e;
      e.k0 = 2'd0;
      e.k1 = 2'd0;
      if (pend == 8'hED) begin
         e.k0 = kind_of(op, 1'b1);
         e.k1 = kind_of(op, 1'b0);
         pend = 8'h00;
      end else if (pend == 8'hCB) begin
         pend = 8'h00;
      end else if (op == 8'hED || op == 8'hCB) begin
         pend = op;
      end
      e.ed = (pend == 8'hED);
      cpu_tick(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom));
      cpu_tick(1'b0, 1'b0, 1'b1, 1'b0, op);
      exp_q.push_back(e);
      cpu_tick(1'b1, 1'b1, 1'b1, 1'b1, 8'($urandom));
   endtask

   task automatic rd_cycle(input logic [7:0] v);
      cpu_tick(1'b1, 1'b0, 1'b1, 1'b0, v);
      idle();
   endtask

   task automatic ack_cycle(input int n);
      for (int i = 0; i < n; i++) cpu_tick(1'b0, 1'b1, 1'b0, 1'b1, 8'hED);
      pend = 8'h00;
      exp_q.push_back('{k0: 2'd0, k1: 2'd0, ed: 1'b0});
      idle();
   endtask

   task automatic bus_idle();
      m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; d = 8'h00; clken = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk({tag, "_spm1"}, spm1[i], 1'b0);
         chk({tag, "_reti"}, reti[i], 1'b0);
         chk({tag, "_retn"}, retn[i], 1'b0);
         chk({tag, "_edm1"}, edm1[i], 1'b0);
      end
   endtask

   // Monitor: pops one expectation per observed M1 close, otherwise pulses must be idle/held
   logic mon_pm1 = 1'b1;
   logic lr [2];
   logic ln [2];
   logic le [2];

   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            mon_pm1 = 1'b1;
            for (int i = 0; i < 2; i++) begin lr[i] = 1'b0; ln[i] = 1'b0; le[i] = 1'b0; end
            continue;
         end
         if (clken) begin
            if (!mon_pm1 && m1_n) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_m1_end", 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  chk("reti_undoc", reti[0], e.k0 == 2'd1);
                  chk("retn_undoc", retn[0], e.k0 == 2'd2);
                  chk("edm1_undoc", edm1[0], e.ed);
                  chk("reti_doc",   reti[1], e.k1 == 2'd1);
                  chk("retn_doc",   retn[1], e.k1 == 2'd2);
                  chk("edm1_doc",   edm1[1], e.ed);
               end
            end else begin
               for (int i = 0; i < 2; i++) begin
                  chk("reti_width", reti[i], 1'b0);
                  chk("retn_width", retn[i], 1'b0);
                  chk("edm1_steady", edm1[i], le[i]);
               end
            end
            mon_pm1 = m1_n;
         end else begin
            for (int i = 0; i < 2; i++) begin
               chk("reti_hold", reti[i], lr[i]);
               chk("retn_hold", retn[i], ln[i]);
               chk("edm1_hold", edm1[i], le[i]);
            end
         end
         for (int i = 0; i < 2; i++) begin lr[i] = reti[i]; ln[i] = retn[i]; le[i] = edm1[i]; end
      end
   end

   initial begin
      int r;
      rst_n = 1'b0;
      bus_idle();
      repeat (3) @(negedge clk);
      chk_all_zero("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("after_reset");

      // RETI with a clock enable every 4th clock, EDM1 between the two fetches
      div = 4;
      fetch(8'hED); idle(); fetch(8'h4D); idle();

      // RETN aliases and a non-RETN ED op
      fetch(8'hED); fetch(8'h45); idle();
      fetch(8'hED); fetch(8'h5D); idle();
      fetch(8'hED); fetch(8'h44); idle();

      // Prefix interaction
      fetch(8'hCB); fetch(8'hED); fetch(8'h4D); idle();
      fetch(8'hDD); fetch(8'hED); fetch(8'h4D); idle();
      fetch(8'hED); fetch(8'hED); fetch(8'h4D); idle();
      fetch(8'hDD); fetch(8'hCB); rd_cycle(8'h05); rd_cycle(8'hED); fetch(8'h4D); idle();

      // HALT-like NOP stream
      repeat (4) fetch(8'h00);

      // Interrupt acknowledge with ED on the bus, then a lone 4D
      ack_cycle(3); fetch(8'h4D); idle();

      // Clock-enable stall while RETI is high
      fetch(8'hED); idle(); fetch(8'h4D);
      clken = 1'b0;
      repeat (20) @(negedge clk);
      chk("stall_reti_undoc", reti[0], 1'b1);
      chk("stall_reti_doc",   reti[1], 1'b1);
      idle();

      // Asynchronous reset while RETI is high
      fetch(8'hED); idle(); fetch(8'h4D);
      chk("pre_reset_reti", reti[0], 1'b1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_reset");
      pend = 8'h00; exp_spm1 = 1'b0;
      bus_idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fetch(8'h4D); idle();

      // Randomised instruction stream
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 7) == 0) div = int'($urandom_range(1, 4));
         r = int'($urandom_range(0, 9));
         if (r == 0)      rd_cycle(8'($urandom));
         else if (r == 1) ack_cycle(int'($urandom_range(1, 3)));
         else if (r == 2) fetch(8'($urandom));
         else             fetch(pool[$urandom_range(0, 12)]);
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();

      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_empty: actual %0d pending required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
